multi_trigger_timer: RTL and testbench
======================================

# multi_trigger_timer

Multi-channel successor to the single-channel trigger timer. A shared free-running counter is captured independently per channel on the first synchronised rising edge of that channel's trigger. The captured values are then read out LSB-first over a serial chain clocked by an external, asynchronous `data_clock`. It sits between the piezo comparator inputs and the host MCU's bit-banged readout, so one block timestamps all sensors against a common time base.

## Interface
- `CHANNELS`, default 4: number of trigger channels, ≥1.
- `WIDTH`, default 32: counter and capture width, ≥2.
- `SYNC_STAGES`, default 2: synchroniser depth for `trigger` and `data_clock`, ≥2.
- `TIMEOUT`, default 1000000: timeout length in clk cycles, ≥1; used only with `TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all state updates on its falling edge.
- `reset`  in  1  asynchronous, active-low reset.
- `trigger`  in  CHANNELS  asynchronous trigger levels, one per channel.
- `arm`  in  1  synchronous re-arm, sampled on the falling edge of `clk`.
- `channel_ready`  out  CHANNELS  per-channel "captured" flags.
- `data_ready`  out  1  high when the capture set is complete.
- `timed_out`  out  1  capture set was completed by timeout.
- `data_clock`  in  1  asynchronous serial shift clock.
- `data_shiftin`  in  1  serial input into the chain MSB.
- `data_shiftout`  out  1  serial output, chain bit 0.

## Operation
- Reset (async, `reset`=0): counter, captures, chain, synchronisers, edge-detect history and timeout counter cleared. Outputs `channel_ready`=0, `data_ready`=0, `timed_out`=0, `data_shiftout`=0.
- Counter: WIDTH bits, +1 every `clk`, wraps modulo 2^WIDTH, never stops or clears except on reset.
- Trigger path: each channel uses a SYNC_STAGES flop synchroniser, then rising-edge detection (previous=0, current=1).
  - On a detected edge with `channel_ready[i]`=0, `cap[i]` loads the counter value of that cycle and `channel_ready[i]` is set.
  - Further edges on that channel are ignored until re-armed.
- `data_ready` = AND of all `channel_ready`, registered.
- `arm`=1 clears `channel_ready`, `data_ready`, `timed_out` and the timeout counter. `cap` contents are retained.
  - `arm` has priority: a trigger edge detected in the same cycle is dropped.
- Serial chain: concatenation {cap[CHANNELS-1], …, cap[0]}, CHANNELS*WIDTH bits.
  - `data_clock` is synchronised and edge-detected like the triggers.
  - On a detected rising edge while `data_ready`=1, the chain shifts right by one and `data_shiftin` enters bit CHANNELS*WIDTH-1.
  - Shift edges while `data_ready`=0 are discarded, so capture and shift never collide.
- `data_shiftout` is registered from chain bit 0 each cycle, reflecting the post-shift value. Readout order is cap[0] LSB first.

## Timing
- Trigger to capture: the captured value equals the counter value SYNC_STAGES+1 falling edges after the input rises (±1 cycle for asynchronous sampling). The offset is identical across channels, so differences are exact to ±1 cycle.
- Last capture to `data_ready`: 1 cycle.
- `data_clock` rise to `data_shiftout` update: SYNC_STAGES+2 falling edges. The host must hold each `data_clock` level for ≥ SYNC_STAGES+1 clk periods.
- Reset mid-capture or mid-readout: all state is lost immediately. Asynchronous deassertion is synchronised by the top level.

## Configuration
- `MULTI_TRIGGER_TIMEOUT_EN` defined: a timeout counter starts on the first capture after arm.
  - After TIMEOUT cycles with captures still missing, every missing channel loads `cap`=all-ones and has its `channel_ready` set. `data_ready` and `timed_out` then go high the next cycle.
  - A capture completing in the same cycle as expiry counts as a normal capture; `timed_out` stays 0 if all channels captured.
- Undefined: no timeout logic. `data_ready` waits indefinitely and `timed_out` is tied 0.

## Test plan
- Reset asserted mid-capture with CHANNELS=4, WIDTH=16 → all outputs 0 immediately, and the chain reads all zeros after arm plus 4 triggers at counter 0.
- Triggers on ch0, ch2, ch1, ch3 at +0, +5, +10, +20 cycles → cap[2]-cap[0]=5, cap[1]-cap[0]=10, cap[3]-cap[0]=20; `data_ready` rises 1 cycle after ch3 capture.
- 64 `data_clock` pulses with `data_shiftin`=0 → `data_shiftout` yields cap[0]..cap[3] LSB first, then reads 0. Pulses applied before `data_ready` produce no shift.
- Second edge on ch0 → cap[0] unchanged. `arm` in the same cycle as a ch1 edge → edge dropped, `channel_ready[1]`=0.
- ch0 captured at counter 0xFFFE and ch1 at 0x0003 → (cap[1]-cap[0]) mod 2^16 = 5.
- `MULTI_TRIGGER_TIMEOUT_EN`, TIMEOUT=100, only ch0 and ch1 triggered → `data_ready`=`timed_out`=1 at 101 cycles after ch0 capture, cap[2]=cap[3]=0xFFFF.

Source files
------------

// File: rtl/multi_trigger_timer_if.sv
// multi_trigger_timer_if: trigger, arm, status and serial readout signals of multi_trigger_timer.
interface multi_trigger_timer_if #(parameter int CHANNELS = 4);
    logic [CHANNELS-1:0] trigger;
    logic arm;
    logic [CHANNELS-1:0] channel_ready;
    logic data_ready;
    logic timed_out;
    logic data_clock;
    logic data_shiftin;
    logic data_shiftout;
    modport master (
        output trigger, arm, data_clock, data_shiftin,
        input channel_ready, data_ready, timed_out, data_shiftout
    );
    modport slave (
        input trigger, arm, data_clock, data_shiftin,
        output channel_ready, data_ready, timed_out, data_shiftout
    );
endinterface

// File: rtl/multi_trigger_timer.sv
// multi_trigger_timer: per-channel trigger timestamps from a shared counter, read out LSB-first over a serial chain.
// Define MULTI_TRIGGER_TIMEOUT_EN to complete a partial capture set after TIMEOUT cycles.
module multi_trigger_timer #(
    parameter int CHANNELS = 4,
    parameter int WIDTH = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT = 1000000
) (
    input logic clk,
    input logic reset,
    multi_trigger_timer_if.slave bus
);
    localparam int N = CHANNELS * WIDTH;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0][CHANNELS-1:0] tsync_q, tsync_d;
    logic [CHANNELS-1:0] tprev_q, tprev_d, ready_q, ready_d, cap_now, fill;
    logic [SYNC_STAGES-1:0] dsync_q, dsync_d;
    logic dprev_q, dprev_d, data_ready_q, data_ready_d, shiftout_q, shiftout_d, shift;
    logic [N-1:0] chain_q, chain_d;

    if (CHANNELS < 1 || WIDTH < 2 || SYNC_STAGES < 2 || TIMEOUT < 1) begin : g_param_check
        $error("multi_trigger_timer: parameter out of range");
    end

    // The capture registers are the chain itself, so readout consumes them.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        tsync_d = {tsync_q[SYNC_STAGES-2:0], bus.trigger};
        tprev_d = tsync_q[SYNC_STAGES-1];
        cap_now = bus.arm ? '0 : tsync_q[SYNC_STAGES-1] & ~tprev_q & ~ready_q;
        dsync_d = {dsync_q[SYNC_STAGES-2:0], bus.data_clock};
        dprev_d = dsync_q[SYNC_STAGES-1];
        shift = dsync_q[SYNC_STAGES-1] & ~dprev_q & data_ready_q;
        chain_d = shift ? {bus.data_shiftin, chain_q[N-1:1]} : chain_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cap_now[i]) chain_d[i*WIDTH +: WIDTH] = cnt_q;
            else if (fill[i]) chain_d[i*WIDTH +: WIDTH] = '1;
        end
        ready_d = bus.arm ? '0 : ready_q | cap_now | fill;
        data_ready_d = ~bus.arm & (&ready_q);
        shiftout_d = chain_q[0];
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            tsync_q <= '0;
            tprev_q <= '0;
            ready_q <= '0;
            dsync_q <= '0;
            dprev_q <= 1'b0;
            data_ready_q <= 1'b0;
            shiftout_q <= 1'b0;
            chain_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            tsync_q <= tsync_d;
            tprev_q <= tprev_d;
            ready_q <= ready_d;
            dsync_q <= dsync_d;
            dprev_q <= dprev_d;
            data_ready_q <= data_ready_d;
            shiftout_q <= shiftout_d;
            chain_q <= chain_d;
        end
    end

`ifdef MULTI_TRIGGER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic to_run_q, to_run_d, to_fired_q, to_fired_d, timed_out_q, timed_out_d, expire;

    // A channel capturing on the expiry cycle keeps its real timestamp.
    always_comb begin
        expire = to_run_q && to_cnt_q == TW'(TIMEOUT - 1) && !(&ready_q);
        fill = (expire && !bus.arm) ? ~ready_q & ~cap_now : '0;
        to_run_d = !bus.arm && !(&(ready_q | cap_now | fill)) && (to_run_q || (|cap_now));
        to_cnt_d = to_run_q ? to_cnt_q + 1'b1 : '0;
        to_fired_d = !bus.arm && (to_fired_q || (|fill));
        timed_out_d = !bus.arm && to_fired_q;
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_q <= '0;
            to_run_q <= 1'b0;
            to_fired_q <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            to_run_q <= to_run_d;
            to_fired_q <= to_fired_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign bus.timed_out = timed_out_q;
`else
    assign fill = '0;
    assign bus.timed_out = 1'b0;
`endif

    assign bus.channel_ready = ready_q;
    assign bus.data_ready = data_ready_q;
    assign bus.data_shiftout = shiftout_q;
endmodule

// File: tb/tb_multi_trigger_timer.sv
// tb_multi_trigger_timer: directed stimulus checked every cycle against a timestamp/chain model, plus literal expectations.
module tb_multi_trigger_timer;
    localparam int C = 4, W = 16, S = 2, TMO = 100;
    logic clk = 1'b1, reset = 1'b0;
    always #5 clk = ~clk;

    multi_trigger_timer_if #(.CHANNELS(C)) bus ();
    multi_trigger_timer #(.CHANNELS(C), .WIDTH(W), .SYNC_STAGES(S), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int checks = 0, errors = 0;
    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: a rise sampled on falling edge k is acted on at edge k+S; counter after edge n equals n.
    typedef struct {int at; int ch;} ev_t;
    ev_t evq[$];
    ev_t e;
    int mcnt = 0;
    logic [C-1:0] m_ready = '0, m_tprev = '0, got;
    logic m_dr = 0, m_to = 0, m_so = 0, m_dprev = 0, nx_dr, nx_to;
    logic [63:0] m_chain = '0;
    int to_start = -1;
    logic to_fired = 0;

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            mcnt = 0; m_ready = '0; m_dr = 0; m_to = 0; m_so = 0; m_chain = '0;
            m_tprev = '0; m_dprev = 0; evq.delete(); to_start = -1; to_fired = 0;
        end else begin
            mcnt++;
            m_so = m_chain[0];
            nx_dr = !bus.arm && (&m_ready);
            nx_to = !bus.arm && to_fired;
            got = '0;
            while (evq.size() > 0 && evq[0].at == mcnt) begin
                e = evq.pop_front();
                if (e.ch < 0) begin
                    if (m_dr) m_chain = {bus.data_shiftin, m_chain[63:1]};
                end else if (!bus.arm && !m_ready[e.ch]) begin
                    m_chain[e.ch*W +: W] = 16'(mcnt - 1);
                    m_ready[e.ch] = 1'b1;
                    got[e.ch] = 1'b1;
                end
            end
`ifdef MULTI_TRIGGER_TIMEOUT_EN
            if (bus.arm) begin
                to_start = -1;
                to_fired = 0;
            end else if (to_start < 0 && got != '0) to_start = mcnt;
            else if (to_start >= 0 && mcnt == to_start + TMO && m_ready != '1) begin
                for (int i = 0; i < C; i++) if (!m_ready[i]) m_chain[i*W +: W] = '1;
                m_ready = '1;
                to_fired = 1;
            end
            m_to = nx_to;
`endif
            if (bus.arm) m_ready = '0;
            m_dr = nx_dr;
            for (int c = 0; c < C; c++) if (bus.trigger[c] && !m_tprev[c]) evq.push_back('{mcnt + S, c});
            if (bus.data_clock && !m_dprev) evq.push_back('{mcnt + S, -1});
            m_tprev = bus.trigger;
            m_dprev = bus.data_clock;
        end
    end

    always @(posedge clk) begin
        check("channel_ready", 64'(bus.channel_ready), 64'(m_ready));
        check("data_ready", 64'(bus.data_ready), 64'(m_dr));
        check("timed_out", 64'(bus.timed_out), 64'(m_to));
        check("data_shiftout", 64'(bus.data_shiftout), 64'(m_so));
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic pulse();
        bus.data_clock = 1'b1;
        tick(4);
        bus.data_clock = 1'b0;
        tick(4);
    endtask
    task automatic arm_pulse();
        bus.arm = 1'b1;
        tick(1);
        bus.arm = 1'b0;
    endtask
    task automatic readout(output logic [63:0] v);
        for (int j = 0; j < 64; j++) begin
            v[j] = bus.data_shiftout;
            pulse();
        end
    endtask

    logic [63:0] v;
    initial begin
        bus.trigger = '0; bus.arm = 1'b0; bus.data_clock = 1'b0; bus.data_shiftin = 1'b0;
        tick(3);
        check("rst channel_ready", 64'(bus.channel_ready), 0);
        check("rst data_ready", 64'(bus.data_ready), 0);
        check("rst timed_out", 64'(bus.timed_out), 0);
        check("rst data_shiftout", 64'(bus.data_shiftout), 0);
        reset = 1'b1;
        tick(2);
        arm_pulse();
        pulse();
        pulse();
        bus.trigger[0] = 1'b1; tick(5);
        bus.trigger[2] = 1'b1; tick(5);
        bus.trigger[1] = 1'b1; tick(10);
        bus.trigger[3] = 1'b1; tick(3);
        check("ready before dr", 64'(bus.channel_ready), 64'hF);
        check("dr not yet", 64'(bus.data_ready), 0);
        tick(1);
        check("dr one after", 64'(bus.data_ready), 1);
`ifndef MULTI_TRIGGER_TIMEOUT_EN
        check("timed_out tied", 64'(bus.timed_out), 0);
`endif
        readout(v);
        check("cap2-cap0", 64'(16'(v[47:32] - v[15:0])), 5);
        check("cap1-cap0", 64'(16'(v[31:16] - v[15:0])), 10);
        check("cap3-cap0", 64'(16'(v[63:48] - v[15:0])), 20);
        pulse();
        pulse();
        check("drained", 64'(bus.data_shiftout), 0);
        bus.trigger = '0;
        tick(4);
        arm_pulse();
        tick(2);
        bus.trigger[0] = 1'b1; tick(4);
        bus.trigger[0] = 1'b0; tick(2);
        bus.trigger[0] = 1'b1; tick(4);
        check("second edge", 64'(bus.channel_ready), 64'h1);
        bus.trigger[1] = 1'b1; tick(2);
        arm_pulse();
        tick(3);
        check("arm drops edge", 64'(bus.channel_ready[1]), 0);
        bus.trigger = '0;
        tick(4);
        while (mcnt != 'hFFFC) tick(1);
        bus.trigger[0] = 1'b1;
        while (mcnt != 'h10001) tick(1);
        bus.trigger[1] = 1'b1; tick(2);
        bus.trigger[3:2] = 2'b11; tick(6);
        check("wrap dr", 64'(bus.data_ready), 1);
        readout(v);
        check("wrap cap0", 64'(v[15:0]), 64'hFFFE);
        check("wrap cap1", 64'(v[31:16]), 64'h0003);
        check("wrap diff", 64'(16'(v[31:16] - v[15:0])), 5);
        bus.trigger = '0;
        tick(4);
        arm_pulse();
        tick(2);
        bus.trigger[0] = 1'b1; tick(4);
        check("pre-reset ready", 64'(bus.channel_ready), 64'h1);
        reset = 1'b0;
        #1;
        check("midrst channel_ready", 64'(bus.channel_ready), 0);
        check("midrst data_ready", 64'(bus.data_ready), 0);
        check("midrst timed_out", 64'(bus.timed_out), 0);
        check("midrst data_shiftout", 64'(bus.data_shiftout), 0);
        tick(2);
        bus.trigger = '0;
        reset = 1'b1;
        tick(2);
        pulse();
        check("postrst shiftout", 64'(bus.data_shiftout), 0);
        check("postrst ready", 64'(bus.channel_ready), 0);
`ifdef MULTI_TRIGGER_TIMEOUT_EN
        arm_pulse();
        tick(2);
        bus.trigger = 4'b0011;
        tick(103);
        check("to dr early", 64'(bus.data_ready), 0);
        check("to flag early", 64'(bus.timed_out), 0);
        tick(1);
        check("to dr", 64'(bus.data_ready), 1);
        check("to flag", 64'(bus.timed_out), 1);
        check("to ready", 64'(bus.channel_ready), 64'hF);
        readout(v);
        check("to cap2", 64'(v[47:32]), 64'hFFFF);
        check("to cap3", 64'(v[63:48]), 64'hFFFF);
        check("to cap1-cap0", 64'(16'(v[31:16] - v[15:0])), 0);
        bus.trigger = '0;
`endif
        tick(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
